// File: rtl/regfile_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
// Build option: DUMP_CHKSUM_EN adds a checksum trailer byte.
package regfile_dump_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = AW_DEF + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_A,
    SEND_B,
    SEND_C,
    DONE
  } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready byte stream carried out of the dump engine.
// Build option: DUMP_CHKSUM_EN (no interface changes).
interface regfile_dump_if #(
  parameter int DW = 8
);

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump.sv
// Walks a register range via two read ports, streams bytes in order.
// Build option: DUMP_CHKSUM_EN appends a mod-256 sum trailer byte.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] src0,
  output logic [AW-1:0] src1,
  input  logic [DW-1:0] outa,
  input  logic [DW-1:0] outb,
  regfile_dump_if.master strm
);

  state_t        r_state;
  state_t        w_next;
  state_t        w_tail;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_src0;
  logic [AW-1:0] r_src1;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_buf_a;
  logic [DW-1:0] r_buf_b;
  logic          r_pair;
  logic          w_hs;
  logic [AW-1:0] w_span;
  logic [AW:0]   w_cnt0;
  logic [AW-1:0] w_ptr1;
  logic [DW-1:0] w_sum;

  assign w_hs   = strm.out_valid && strm.out_ready;
  assign w_span = last - first;
  assign w_cnt0 = {1'b0, w_span} + (AW+1)'(1);
  assign w_ptr1 = r_ptr + AW'(1);

`ifdef DUMP_CHKSUM_EN
  logic [DW-1:0] r_sum;

  assign w_tail = SEND_C;
  assign w_sum  = r_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (r_state == IDLE && start) begin
      r_sum <= '0;
    end else if (w_hs && (r_state == SEND_A ||
                          r_state == SEND_B)) begin
      r_sum <= r_sum + strm.out_data;
    end
  end
`else
  assign w_tail = DONE;
  assign w_sum  = '0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   w_next = SEND_A;
      SEND_A:  if (w_hs) w_next = r_pair ? SEND_B : w_tail;
      SEND_B:  if (w_hs) begin
        w_next = (r_cnt > (AW+1)'(2)) ? FETCH : w_tail;
      end
      SEND_C:  if (w_hs) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    strm.out_valid = 1'b0;
    strm.out_data  = '0;
    unique case (r_state)
      SEND_A: begin
        strm.out_valid = 1'b1;
        strm.out_data  = r_buf_a;
      end
      SEND_B: begin
        strm.out_valid = 1'b1;
        strm.out_data  = r_buf_b;
      end
      SEND_C: begin
        strm.out_valid = 1'b1;
        strm.out_data  = w_sum;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  // Addresses hold their fetch values so the file sees no churn
  assign src0 = (r_state == FETCH) ? r_ptr  : r_src0;
  assign src1 = (r_state == FETCH) ? w_ptr1 : r_src1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_src0  <= '0;
      r_src1  <= '0;
      r_buf_a <= '0;
      r_buf_b <= '0;
      r_pair  <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (start) begin
          r_ptr <= first;
          r_cnt <= w_cnt0;
        end
        FETCH: begin
          r_src0  <= r_ptr;
          r_src1  <= w_ptr1;
          r_buf_a <= outa;
          r_buf_b <= outb;
          r_pair  <= (r_cnt >= (AW+1)'(2));
        end
        SEND_A: if (w_hs && !r_pair) begin
          r_cnt <= r_cnt - (AW+1)'(1);
        end
        SEND_B: if (w_hs) begin
          r_ptr <= r_ptr + AW'(2);
          r_cnt <= r_cnt - (AW+1)'(2);
        end
        default: ;
      endcase
    end
  end

endmodule
